// File: rtl/uart_hex_dump.sv
// Snapshots N_WORDS 32-bit words and sends them over UART as uppercase hex text ending in CR LF.
// Define UART_PARITY_EN to add an even parity bit to every frame.
module uart_hex_dump #(
   parameter int CLK_DIV = 868,
   parameter int N_WORDS = 8,
   parameter int PERIOD  = 10000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [32*N_WORDS-1:0]  data,
   output logic                   tx,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      NEXT   = 3'd5
   } state_t;

   localparam int CW = $clog2(CLK_DIV);
   localparam int WW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(N_WORDS - 1);
   localparam logic [PW-1:0] PER_LAST  = PW'((PERIOD > 0) ? PERIOD - 1 : 0);
   localparam logic          AUTO_EN   = (PERIOD != 0);

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end else begin
         return 8'h37 + {4'h0, nib};
      end
   endfunction

`ifdef UART_PARITY_EN
   function automatic logic even_par(input logic [7:0] b);
      return ^b;
   endfunction
`endif

   state_t                state_r, state_nx_s;
   logic [CW-1:0]         bit_cnt_r, bit_cnt_nx_s;
   logic [2:0]            bit_idx_r, bit_idx_nx_s;
   logic [WW-1:0]         word_idx_r, word_idx_nx_s;
   logic [3:0]            nib_idx_r, nib_idx_nx_s;   // 0..7 hex digit, 8 = separator
   logic [1:0]            crlf_r, crlf_nx_s;         // 0 = word text, 1 = CR, 2 = LF
   logic [PW-1:0]         period_cnt_r;
   logic [32*N_WORDS-1:0] snap_r;
   logic [31:0]           word_s;
   logic [3:0]            nib_s;
   logic [7:0]            char_s;
   logic                  trig_s, bit_end_s, snap_ld_s;
   logic                  busy_nx_s, done_nx_s, tx_nx_s;
   logic                  tx_r, busy_r, done_r;

   assign trig_s    = start | (AUTO_EN & (period_cnt_r == PER_LAST));
   assign bit_end_s = (bit_cnt_r == BIT_LAST);
   assign nib_s     = 4'(word_s >> {~nib_idx_r[2:0], 2'b00});
   assign tx        = tx_r;
   assign busy      = busy_r;
   assign done      = done_r;

   // Select the snapshot word being printed.
   always_comb begin
      word_s = snap_r[31:0];
      for (int i = 1; i < N_WORDS; i++) begin
         word_s = (word_idx_r == WW'(i)) ? snap_r[32*i +: 32] : word_s;
      end
   end

   // Current character of the text stream.
   always_comb begin
      if (crlf_r == 2'd1) begin
         char_s = 8'h0D;
      end else if (crlf_r == 2'd2) begin
         char_s = 8'h0A;
      end else if (nib_idx_r == 4'd8) begin
         char_s = 8'h20;
      end else begin
         char_s = hex_ascii(nib_s);
      end
   end

   // Next-state logic; tx is derived from the next state so the line register changes with it.
   always_comb begin
      state_nx_s    = state_r;
      bit_cnt_nx_s  = bit_end_s ? '0 : bit_cnt_r + CW'(1);
      bit_idx_nx_s  = bit_idx_r;
      word_idx_nx_s = word_idx_r;
      nib_idx_nx_s  = nib_idx_r;
      crlf_nx_s     = crlf_r;
      snap_ld_s     = 1'b0;
      busy_nx_s     = busy_r;
      done_nx_s     = 1'b0;
      case (state_r)
         IDLE: begin
            bit_cnt_nx_s = '0;
            if (trig_s) begin
               state_nx_s    = START;
               bit_idx_nx_s  = 3'd0;
               word_idx_nx_s = '0;
               nib_idx_nx_s  = 4'd0;
               crlf_nx_s     = 2'd0;
               snap_ld_s     = 1'b1;
               busy_nx_s     = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_nx_s = DATA;
            end else begin
               state_nx_s = START;
            end
         end
         DATA: begin
            if (bit_end_s && bit_idx_r == 3'd7) begin
               bit_idx_nx_s = 3'd0;
`ifdef UART_PARITY_EN
               state_nx_s   = PARITY;
`else
               state_nx_s   = STOP;
`endif
            end else if (bit_end_s) begin
               bit_idx_nx_s = bit_idx_r + 3'd1;
            end else begin
               bit_idx_nx_s = bit_idx_r;
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (bit_end_s) begin
               state_nx_s = STOP;
            end else begin
               state_nx_s = PARITY;
            end
         end
`endif
         STOP: begin
            if (bit_end_s) begin
               state_nx_s = NEXT;
            end else begin
               state_nx_s = STOP;
            end
         end
         NEXT: begin
            bit_cnt_nx_s = '0;
            if (crlf_r == 2'd2) begin
               state_nx_s = IDLE;
               busy_nx_s  = 1'b0;
               done_nx_s  = 1'b1;
            end else begin
               state_nx_s = START;
               if (crlf_r == 2'd1) begin
                  crlf_nx_s = 2'd2;
               end else if (nib_idx_r == 4'd8) begin
                  nib_idx_nx_s  = 4'd0;
                  word_idx_nx_s = word_idx_r + WW'(1);
               end else if (nib_idx_r != 4'd7) begin
                  nib_idx_nx_s = nib_idx_r + 4'd1;
               end else if (word_idx_r == WORD_LAST) begin
                  crlf_nx_s = 2'd1;
               end else begin
                  nib_idx_nx_s = 4'd8;
               end
            end
         end
         default: begin
            state_nx_s   = IDLE;
            bit_cnt_nx_s = '0;
            busy_nx_s    = 1'b0;
         end
      endcase

      case (state_nx_s)
         START:   tx_nx_s = 1'b0;
         DATA:    tx_nx_s = char_s[bit_idx_nx_s];
`ifdef UART_PARITY_EN
         PARITY:  tx_nx_s = even_par(char_s);
`endif
         default: tx_nx_s = 1'b1;
      endcase
   end

   // FSM, counters, snapshot and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         bit_cnt_r  <= '0;
         bit_idx_r  <= 3'd0;
         word_idx_r <= '0;
         nib_idx_r  <= 4'd0;
         crlf_r     <= 2'd0;
         snap_r     <= '0;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         bit_cnt_r  <= bit_cnt_nx_s;
         bit_idx_r  <= bit_idx_nx_s;
         word_idx_r <= word_idx_nx_s;
         nib_idx_r  <= nib_idx_nx_s;
         crlf_r     <= crlf_nx_s;
         snap_r     <= snap_ld_s ? data : snap_r;
         tx_r       <= tx_nx_s;
         busy_r     <= busy_nx_s;
         done_r     <= done_nx_s;
      end
   end

   // Free-running auto-trigger counter, independent of busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         period_cnt_r <= '0;
      end else if (AUTO_EN && period_cnt_r != PER_LAST) begin
         period_cnt_r <= period_cnt_r + PW'(1);
      end else begin
         period_cnt_r <= '0;
      end
   end

endmodule

// File: tb/tb_uart_hex_dump.sv
// Self-checking bench: logs tx/busy/done every cycle, decodes the UART stream and compares with a text model.
module tb_uart_hex_dump;
   localparam int DIV = 4;
`ifdef UART_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FR   = DIV * (10 + P) + 1;
   localparam int L0   = 10 * FR;
   localparam int L1   = 19 * FR;
   localparam int MAXC = 8000;

   logic        clk = 1'b0;
   logic        rst0 = 1'b1, rst1 = 1'b1;
   logic        start0 = 1'b0, start1 = 1'b0;
   logic [31:0] data0 = 32'h0;
   logic [63:0] data1 = {32'h0000_0000, 32'hDEAD_BEEF};
   logic        tx0, busy0, done0, tx1, busy1, done1;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int R;
   logic tx0_log [MAXC];
   logic busy0_log [MAXC];
   logic done0_log [MAXC];
   logic tx1_log [MAXC];
   logic [7:0] rx_q[$];
   int         rx_at[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_hex_dump #(.CLK_DIV(DIV), .N_WORDS(1), .PERIOD(0)) u0 (
      .clk(clk), .rst(rst0), .start(start0), .data(data0),
      .tx(tx0), .busy(busy0), .done(done0));

   uart_hex_dump #(.CLK_DIV(DIV), .N_WORDS(2), .PERIOD(1000)) u1 (
      .clk(clk), .rst(rst1), .start(start1), .data(data1),
      .tx(tx1), .busy(busy1), .done(done1));

   // Per-cycle record of outputs, indexed by rising-edge number.
   always @(posedge clk) begin
      #1;
      if (cyc < MAXC) begin
         tx0_log[cyc]   <= tx0;
         busy0_log[cyc] <= busy0;
         done0_log[cyc] <= done0;
         tx1_log[cyc]   <= tx1;
      end
      cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic txbit(input int u, input int i);
      if (i >= MAXC) return 1'bx;
      return (u == 1) ? tx1_log[i] : tx0_log[i];
   endfunction

   function automatic int count_ones(input int sel, input int a, input int b);
      int   n = 0;
      logic v;
      for (int i = a; i <= b; i++) begin
         case (sel)
            0:       v = tx0_log[i];
            1:       v = busy0_log[i];
            2:       v = done0_log[i];
            default: v = tx1_log[i];
         endcase
         if (v === 1'b1) n++;
      end
      return n;
   endfunction

   // Expected text: 8 hex digits per word, space between words, CR LF at the end.
   task automatic model(input int nw, input logic [31:0] w0, input logic [31:0] w1);
      logic [31:0] wd;
      logic [3:0]  nib;
      exp_q.delete();
      for (int i = 0; i < nw; i++) begin
         wd = (i == 0) ? w0 : w1;
         for (int n = 7; n >= 0; n--) begin
            nib = 4'((wd >> (4 * n)) & 32'hF);
            exp_q.push_back((nib < 4'd10) ? 8'h30 + 8'(nib) : 8'h41 + 8'(nib) - 8'd10);
         end
         if (i != nw - 1) exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic decode(input int u, input int from, input int to);
      logic [7:0] c;
      int i = from;
      rx_q.delete();
      rx_at.delete();
      while (i < to) begin
         if (txbit(u, i) === 1'b0) begin
            for (int b = 0; b < 8; b++) c[b] = txbit(u, i + DIV * (1 + b) + DIV / 2);
`ifdef UART_PARITY_EN
            check1("parity", txbit(u, i + DIV * 9 + DIV / 2), ^c);
`endif
            check1("stop", txbit(u, i + DIV * (9 + P) + DIV / 2), 1'b1);
            rx_q.push_back(c);
            rx_at.push_back(i);
            i = i + DIV * (10 + P);
         end else begin
            i++;
         end
      end
   endtask

   task automatic compare_stream(input string tag);
      int n;
      check({tag, "_nchars"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_char%0d", tag, i), {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
         if (i > 0) check($sformatf("%s_gap%0d", tag, i), rx_at[i] - rx_at[i-1], FR);
      end
   endtask

   task automatic run_dump(input logic [31:0] w);
      int k;
      data0 = w;
      start0 = 1'b1;
      k = cyc;
      @(negedge clk);
      start0 = 1'b0;
      data0 = 32'hFFFF_FFFF;
      while (cyc <= k + L0 + 2) @(negedge clk);
      check1("tx_idle_before", tx0_log[k-1], 1'b1);
      check1("tx_fall", tx0_log[k], 1'b0);
      check("busy_len", count_ones(1, k - 1, k + L0), L0);
      check1("done_at_end", done0_log[k+L0], 1'b1);
      check("done_once", count_ones(2, k - 1, k + L0 + 2), 1);
      model(1, w, 32'h0);
      decode(0, k, k + L0);
      compare_stream("dump");
   endtask

   initial begin
      int k, k2, m;
      logic [31:0] w, w2;
      #1;
      rst0 = 1'b0;
      rst1 = 1'b0;
      #2;
      check1("rst_tx0", tx0, 1'b1);
      check1("rst_busy0", busy0, 1'b0);
      check1("rst_done0", done0, 1'b0);
      check1("rst_tx1", tx1, 1'b1);
      check1("rst_busy1", busy1, 1'b0);
      repeat (2) @(negedge clk);
      rst0 = 1'b1;
      rst1 = 1'b1;
      R = cyc;
      repeat (3) @(negedge clk);

      run_dump(32'h1234_ABCD);
      run_dump(32'h0000_0007);
      for (int t = 0; t < 3; t++) run_dump($urandom);

      // Starts during a dump are dropped; a start on the done cycle is accepted.
      w = $urandom;
      data0 = w;
      start0 = 1'b1;
      k = cyc;
      @(negedge clk);
      start0 = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         while (cyc < k + 50 * j) @(negedge clk);
         start0 = 1'b1;
         data0 = $urandom;
         @(negedge clk);
         start0 = 1'b0;
      end
      while (cyc < k + L0 + 1) @(negedge clk);
      w2 = $urandom;
      data0 = w2;
      start0 = 1'b1;
      k2 = cyc;
      @(negedge clk);
      start0 = 1'b0;
      data0 = $urandom;
      while (cyc <= k2 + L0 + 2) @(negedge clk);
      check("drop_busy_len", count_ones(1, k, k + L0), L0);
      check("drop_done_once", count_ones(2, k, k + L0), 1);
      check1("drop_done_edge", done0_log[k+L0], 1'b1);
      model(1, w, 32'h0);
      decode(0, k, k + L0);
      compare_stream("drop");
      check1("b2b_tx_fall", tx0_log[k2], 1'b0);
      check1("b2b_busy", busy0_log[k2], 1'b1);
      check("b2b_done_once", count_ones(2, k2, k2 + L0 + 2), 1);
      model(1, w2, 32'h0);
      decode(0, k2, k2 + L0);
      compare_stream("b2b");

      // Reset in the middle of a DATA bit that is 0.
      data0 = 32'h0;
      start0 = 1'b1;
      k = cyc;
      @(negedge clk);
      start0 = 1'b0;
      while (cyc < k + 12) @(negedge clk);
      check1("pre_rst_tx", tx0, 1'b0);
      check1("pre_rst_busy", busy0, 1'b1);
      #2;
      rst0 = 1'b0;
      #1;
      check1("mid_rst_tx", tx0, 1'b1);
      check1("mid_rst_busy", busy0, 1'b0);
      check1("mid_rst_done", done0, 1'b0);
      @(negedge clk);
      rst0 = 1'b1;
      m = cyc;
      while (cyc <= m + 100) @(negedge clk);
      check("post_rst_tx_high", count_ones(0, m, m + 100), 101);
      check("post_rst_busy_low", count_ones(1, m, m + 100), 0);
      run_dump($urandom);

      // Auto-trigger instance: dumps at cycles 999 and 1999 after release.
      while (cyc < R + 1999 + L1 + 5) @(negedge clk);
      check1("auto1_idle", tx1_log[R+998], 1'b1);
      check1("auto1_fall", tx1_log[R+999], 1'b0);
      model(2, 32'hDEAD_BEEF, 32'h0000_0000);
      decode(1, R + 999, R + 999 + L1);
      compare_stream("auto");
      check1("auto2_idle", tx1_log[R+1998], 1'b1);
      check1("auto2_fall", tx1_log[R+1999], 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_hex_dump.md
UART_HEX_DUMP -- requirements
Module: uart_hex_dump

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, clk cycles per UART bit (legal range >= 2).
REQ-002 SHALL have parameter N_WORDS, default 8, number of 32-bit words per dump (legal range >= 1).
REQ-003 SHALL have parameter PERIOD, default 10000000, auto-trigger interval in clk cycles; 0 disables auto-trigger.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle dump request.
REQ-007 SHALL have port data  input  32*N_WORDS  snapshot source; word i = data[32*i+31:32*i].
REQ-008 SHALL have port tx  output  1  UART serial line; idle high.
REQ-009 SHALL have port busy  output  1  high while a dump is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at dump completion.

Function
REQ-011 A trigger SHALL be start=1, or the period counter reaching PERIOD-1 when PERIOD != 0.
REQ-012 The period counter SHALL run freely from 0 to PERIOD-1, wrap to 0, and count regardless of busy.
REQ-013 A trigger seen in IDLE SHALL latch all of data into a snapshot register at that edge; busy SHALL be 1 from the next cycle.
REQ-014 Triggers arriving while busy=1 SHALL be dropped with no queuing; simultaneous start and period triggers SHALL count as one dump.
REQ-015 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP, NEXT. Transitions:
- IDLE->START on trigger
- START->DATA after 1 bit time
- DATA->PARITY or STOP after 8 bits
- PARITY->STOP after 1 bit time
- STOP->NEXT after 1 bit time
- NEXT->START if characters remain, else NEXT->IDLE
REQ-016 Every bit SHALL last exactly CLK_DIV cycles, timed by a bit counter that resets on each bit.
REQ-017 The frame SHALL be start bit 0, then 8 data bits LSB first, then optional parity (REQ-027), then stop bit 1; tx SHALL be a registered output.
REQ-018 NEXT SHALL last 1 cycle with tx=1 and SHALL add exactly 1 cycle between consecutive frames.
REQ-019 The character stream SHALL be:
- for each word i = 0..N_WORDS-1, 8 uppercase ASCII hex digits, most significant nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46)
- 0x20 after every word except the last
- then 0x0D, 0x0A
- total 9*N_WORDS+1 characters
REQ-020 Word and nibble indices SHALL be $clog2-sized and SHALL be derived only from the snapshot, never from live data.
REQ-021 tx SHALL fall at the first edge after the trigger.
REQ-022 done SHALL pulse for 1 cycle and busy SHALL fall at the same edge, when the final NEXT cycle exits to IDLE.
REQ-023 A trigger in the cycle where done=1 SHALL be accepted, giving back-to-back dumps.

Reset
REQ-024 When rst=0, outputs SHALL immediately become tx=1, busy=0, done=0; the FSM SHALL be in IDLE and all counters and the snapshot SHALL be 0.
REQ-025 Reset mid-frame SHALL abort the dump without completing the frame; after release, no dump SHALL start until the next trigger.
REQ-026 The period counter SHALL restart from 0 on reset release.

Configuration
REQ-027 With macro UART_PARITY_EN defined, STATE PARITY SHALL send an even parity bit (XOR of the 8 data bits) after the data bits, making an 11-bit frame.
REQ-028 Without UART_PARITY_EN, PARITY SHALL never be entered, the frame SHALL be 10 bits, and no parity logic SHALL be synthesised.

Verification
REQ-029 Single word: CLK_DIV=4, N_WORDS=1, PERIOD=0, no parity, data=0x1234ABCD, 1-cycle start.
- tx decodes 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0D 0x0A
- busy high for 10*(40+1)=410 cycles
- done pulses once
REQ-030 Snapshot isolation: same setup as REQ-029; change data to 0xFFFFFFFF one cycle after start.
- output is still "1234ABCD\r\n"
REQ-031 Dropped triggers: start pulsed every 50 cycles during a dump.
- exactly one dump occurs
- a start on the done cycle begins a second dump with tx=0 at the next edge
REQ-032 Auto-trigger and separator: PERIOD=1000, N_WORDS=2, CLK_DIV=4, data = {0x00000000, 0xDEADBEEF}.
- a dump starts at cycle 999
- stream is "DEADBEEF 00000000\r\n" (19 characters)
- next dump starts at cycle 1999
REQ-033 Parity: UART_PARITY_EN defined, data=0x00000007.
- character '7' (0x37) frame has parity bit 1
- character '0' (0x30) frame has parity bit 0
- each frame is 44 cycles at CLK_DIV=4
REQ-034 Reset mid-frame: drop rst mid-frame in DATA state.
- tx=1, busy=0 with no clock edge
- after release, tx stays 1 until the next start
